// File: rtl/alu_pkg.sv
// Shared encodings for the ALU op select, multiply/divide op select and MDU
// sequencer states.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_XOR  = 4'b0011,
      ALU_NOR  = 4'b0100,
      ALU_SLTU = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_SLL  = 4'b1000,
      ALU_SRL  = 4'b1001,
      ALU_SRA  = 4'b1010,
      ALU_LUI  = 4'b1011
   } alu_op_e;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_RUN  = 2'b01,
      MD_DONE = 2'b10
   } md_state_e;

   function automatic logic md_is_div(input logic [1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine: one bit per cycle on operand magnitudes,
// sign fix-up applied as the result is written to hi/lo.
module muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   md_state_e          state_reg;
   logic [CW-1:0]      cnt_reg;
   logic               is_div_reg;
   logic               neg_q_reg;
   logic               neg_r_reg;
   logic [WIDTH-1:0]   opnd_reg;
   logic [WIDTH-1:0]   acc_reg;
   logic [WIDTH-1:0]   ql_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               busy_reg;
   logic               done_reg;
   logic               divzero_reg;

   logic               sgn;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   acc_next;
   logic [WIDTH-1:0]   ql_next;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      sgn   = md_is_signed(op);
      a_neg = sgn & a[WIDTH-1];
      b_neg = sgn & b[WIDTH-1];
      mag_a = a_neg ? (~a + 1'b1) : a;
      mag_b = b_neg ? (~b + 1'b1) : b;
   end

   // Multiply keeps {acc, ql} as the shifting product with the multiplier in ql;
   // divide keeps the partial remainder in acc and shifts quotient bits into ql.
   always_comb begin
      sum     = {1'b0, acc_reg} + {1'b0, opnd_reg};
      shifted = {acc_reg, ql_reg[WIDTH-1]};
      diff    = shifted - {1'b0, opnd_reg};
      if (is_div_reg) begin
         if (!diff[WIDTH]) begin
            acc_next = diff[WIDTH-1:0];
            ql_next  = {ql_reg[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = shifted[WIDTH-1:0];
            ql_next  = {ql_reg[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (ql_reg[0]) begin
            acc_next = sum[WIDTH:1];
            ql_next  = {sum[0], ql_reg[WIDTH-1:1]};
         end else begin
            acc_next = {1'b0, acc_reg[WIDTH-1:1]};
            ql_next  = {acc_reg[0], ql_reg[WIDTH-1:1]};
         end
      end
   end

   always_comb begin
      prod     = {acc_next, ql_next};
      prod_fix = neg_q_reg ? (~prod + 1'b1) : prod;
      quo_fix  = neg_q_reg ? (~ql_next + 1'b1) : ql_next;
      rem_fix  = neg_r_reg ? (~acc_next + 1'b1) : acc_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= MD_IDLE;
         cnt_reg     <= '0;
         is_div_reg  <= 1'b0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
         opnd_reg    <= '0;
         acc_reg     <= '0;
         ql_reg      <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         divzero_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            MD_IDLE: begin
               if (start) begin
                  busy_reg    <= 1'b1;
                  divzero_reg <= 1'b0;
                  cnt_reg     <= '0;
                  is_div_reg  <= md_is_div(op);
                  neg_q_reg   <= a_neg ^ b_neg;
                  neg_r_reg   <= a_neg & md_is_div(op);
                  acc_reg     <= '0;
                  opnd_reg    <= md_is_div(op) ? mag_b : mag_a;
                  ql_reg      <= md_is_div(op) ? mag_a : mag_b;
                  // A zero divisor short-circuits straight to the result.
                  if (md_is_div(op) && (b == '0)) begin
                     state_reg   <= MD_DONE;
                     hi_reg      <= a;
                     lo_reg      <= '1;
                     divzero_reg <= 1'b1;
                     done_reg    <= 1'b1;
                  end else begin
                     state_reg <= MD_RUN;
                  end
               end
            end
            MD_RUN: begin
               acc_reg <= acc_next;
               ql_reg  <= ql_next;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == LAST) begin
                  state_reg <= MD_DONE;
                  done_reg  <= 1'b1;
                  cnt_reg   <= '0;
                  if (is_div_reg) begin
                     hi_reg <= rem_fix;
                     lo_reg <= quo_fix;
                  end else begin
                     hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                     lo_reg <= prod_fix[WIDTH-1:0];
                  end
               end
            end
            MD_DONE: begin
               state_reg <= MD_IDLE;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= MD_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign divzero = divzero_reg;
   assign hi      = hi_reg;
   assign lo      = lo_reg;

endmodule

// File: rtl/alu_muldiv.sv
// Combinational ALU alongside an iterative multiply/divide unit; the ALU path
// never depends on the sequencer.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   input  logic [3:0]       alucontrol,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   input  logic             md_start,
   input  logic [1:0]       md_op,
   output logic             md_busy,
   output logic             md_done,
   output logic             md_divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] dif;

   always_comb begin
      sum      = a + b;
      dif      = a - b;
      result   = '0;
      overflow = 1'b0;
      case (alu_op_e'(alucontrol))
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_ADD: begin
            result   = sum;
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
         ALU_SUB: begin
            result   = dif;
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLL:  result = b << shamt;
         ALU_SRL:  result = b >> shamt;
         ALU_SRA:  result = $signed(b) >>> shamt;
         ALU_LUI:  result = b << (WIDTH / 2);
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

   muldiv_seq #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk     (clk),
      .reset   (reset),
      .start   (md_start),
      .op      (md_op),
      .a       (a),
      .b       (b),
      .busy    (md_busy),
      .done    (md_done),
      .divzero (md_divzero),
      .hi      (hi),
      .lo      (lo)
   );

endmodule
